xbar_arbiter: RTL and testbench
===============================

Name: xbar_arbiter

Overview:
- Per-output round-robin scheduler for the 8x8 crossbar.
- Each input port posts a request naming one destination output port.
- For every output, the block grants one input and holds the connection locked until that input signals end-of-packet.
- It drives the crossbar's per-output select lines and per-input grant acknowledges, in the same clk domain as the crossbar.

Parameters:
- PORTS, 8, number of input ports and number of output ports (matches package value ports).
- SEL_W, $clog2(PORTS), width of a port index.
- MAX_HOLD, 1024, cycles a connection may stay locked without EOP (used only with timeout feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  PORTS  input i has a packet pending.
- req_dest  in  PORTS*SEL_W  destination of input i; slice [i*SEL_W +: SEL_W].
- req_eop  in  PORTS  1-cycle pulse: input i's final bit/word transfers this cycle.
- grant  out  PORTS  input i currently owns its destination output.
- out_sel  out  PORTS*SEL_W  for output j, the index of the input driving it; slice [j*SEL_W +: SEL_W].
- out_busy  out  PORTS  output j locked.
- timeout_pulse  out  PORTS  1-cycle pulse when output j is force-released (tied 0 without feature).

Behaviour:
- Reset: grant=0, out_sel=0, out_busy=0, timeout_pulse=0, all RR pointers=0, all outputs IDLE. Reset mid-packet drops all connections immediately; no EOP is needed afterwards.
- Per-output FSM, states IDLE and BUSY.
- IDLE, output j:
  - Candidates are inputs i with req_valid[i]=1, req_dest[i]==j and grant[i]=0.
  - Winner is the first candidate found searching from ptr[j] upward, wrapping PORTS-1 to 0.
  - Decision is registered. If a request is visible in cycle t, then at t+1: out_busy[j]=1, out_sel[j]=winner, grant[winner]=1, ptr[j]=(winner+1) mod PORTS.
  - No candidate: stay IDLE; out_sel[j] holds its last value.
- BUSY, output j, owner k:
  - req_eop[k]=1 in cycle t: at t+1, grant[k]=0, out_busy[j]=0, state IDLE.
  - Re-arbitration uses the request state at t+1, so the next grant comes at t+2 earliest. There is a guaranteed one-cycle gap between packets on an output.
- Lock rules while BUSY:
  - Changes to req_dest[k] and req_valid[k] are ignored.
  - Dropping req_valid[k] does not release; only EOP (or timeout) releases.
- Ignored inputs:
  - req_eop[i] while grant[i]=0.
  - req_dest >= PORTS (only reachable when PORTS is not a power of 2): never granted.
- All outputs arbitrate independently and in parallel in the same cycle.
  - An input requests exactly one destination, so it never holds two grants.
- Fairness: with N persistent requesters for one output, each is granted once per N packets.
- Simultaneous events:
  - EOP from owner plus new requests in the same cycle: the release takes effect first. New requests compete at t+1 with the updated pointer.
  - Owner re-requests the same output after its EOP: it competes normally and, by the pointer, has lowest priority.

Optional Feature:
- Macro: XBAR_ARB_TIMEOUT_EN.
- Defined:
  - Each BUSY output has a hold counter, zeroed on grant and incremented every BUSY cycle.
  - When the counter reaches MAX_HOLD-1 with no EOP, the next cycle releases exactly as an EOP would and pulses timeout_pulse[j] for 1 cycle.
  - EOP in the same cycle as expiry counts as a normal release; no pulse.
- Undefined: no counters are built; timeout_pulse is constant 0; a lock persists until EOP or rst.

Test Plan:
- Reset then idle: rst high 2 cycles, req_valid=0 -> grant=0, out_busy=0, out_sel all 0, steady for 20 cycles.
- Single request: input 3 requests dest 5 at cycle t -> at t+1, grant[3]=1, out_busy[5]=1, out_sel[5]=3. req_eop[3] at t+10 -> at t+11, grant[3]=0 and out_busy[5]=0.
- Round-robin on one output: inputs 0, 2 and 6 all request dest 1 persistently, each sending EOP 4 cycles after its grant -> grant order is 0, 2, 6, 0, with exactly one idle cycle between grants.
- Parallel outputs and lock: input i requests dest 7-i for i=0..7 -> all 8 grants at t+1, out_sel[j]=7-j. Changing input 0's req_dest to 3 mid-packet leaves out_sel[7]=0 and grant[0]=1 until EOP.
- Reset mid-packet: inputs 1->2 and 4->2, input 1 granted; rst pulses -> next cycle all outputs 0. After rst releases, input 1 regains output 2 first because ptr resets to 0.
- Timeout, XBAR_ARB_TIMEOUT_EN with MAX_HOLD=16: input 5 is granted dest 0 and never asserts EOP -> 16 cycles after grant, timeout_pulse[0]=1 for 1 cycle, grant[5]=0, out_busy[0]=0. Without the macro, the grant persists for 100 cycles.

Source files
------------

// File: rtl/xbar_arbiter_if.sv
// rtl/xbar_arbiter_if.sv - request/grant bundle between crossbar input ports and the per-output arbiter
interface xbar_arbiter_if #(
    parameter int PORTS = 8,
    parameter int SEL_W = $clog2(PORTS)
);
    logic [PORTS-1:0]       req_valid;
    logic [PORTS*SEL_W-1:0] req_dest;
    logic [PORTS-1:0]       req_eop;
    logic [PORTS-1:0]       grant;
    logic [PORTS*SEL_W-1:0] out_sel;
    logic [PORTS-1:0]       out_busy;
    logic [PORTS-1:0]       timeout_pulse;

    modport master (
        output req_valid, req_dest, req_eop,
        input  grant, out_sel, out_busy, timeout_pulse
    );

    modport slave (
        input  req_valid, req_dest, req_eop,
        output grant, out_sel, out_busy, timeout_pulse
    );
endinterface

// File: rtl/xbar_arbiter.sv
// rtl/xbar_arbiter.sv - per-output round-robin scheduler for the crossbar; XBAR_ARB_TIMEOUT_EN adds hold-timeout release
module xbar_arbiter #(
    parameter int PORTS    = 8,
    parameter int SEL_W    = $clog2(PORTS),
    parameter int MAX_HOLD = 1024
) (
    input  logic          clk,
    input  logic          rst,
    xbar_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state   [PORTS];
    logic [SEL_W-1:0]       ptr     [PORTS];
    logic [PORTS-1:0]       grant_q;
    logic [PORTS-1:0]       busy_q;
    logic [PORTS*SEL_W-1:0] sel_q;

    logic [PORTS-1:0]       cand    [PORTS];
    logic [PORTS-1:0]       win_found;
    logic [SEL_W-1:0]       win_idx [PORTS];
    logic [SEL_W-1:0]       scan_idx;
    logic [SEL_W-1:0]       owner   [PORTS];
    logic [PORTS-1:0]       owner_eop;
    logic [PORTS-1:0]       expire;

    // An input already holding a grant is excluded so it can never own two outputs.
    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            for (int i = 0; i < PORTS; i++) begin
                cand[j][i] = bus.req_valid[i] && !grant_q[i]
                             && (int'(bus.req_dest[i*SEL_W +: SEL_W]) == j);
            end
        end
    end

    always_comb begin
        scan_idx = '0;
        for (int j = 0; j < PORTS; j++) begin
            win_found[j] = 1'b0;
            win_idx[j]   = '0;
            for (int off = 0; off < PORTS; off++) begin
                scan_idx = SEL_W'((int'(ptr[j]) + off) % PORTS);
                if (!win_found[j] && cand[j][scan_idx]) begin
                    win_found[j] = 1'b1;
                    win_idx[j]   = scan_idx;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            owner[j]     = sel_q[j*SEL_W +: SEL_W];
            owner_eop[j] = bus.req_eop[owner[j]];
        end
    end

`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold [PORTS];
    logic [PORTS-1:0]  to_q;

    always_comb begin
        for (int j = 0; j < PORTS; j++) begin
            expire[j] = (hold[j] == HOLD_W'(MAX_HOLD - 1));
        end
    end

    assign bus.timeout_pulse = to_q;
`else
    assign expire = '0;
    // MAX_HOLD has no effect when the hold counters are not built.
    assign bus.timeout_pulse = (MAX_HOLD > 0) ? '0 : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            busy_q  <= '0;
            sel_q   <= '0;
            for (int j = 0; j < PORTS; j++) begin
                state[j] <= IDLE;
                ptr[j]   <= '0;
            end
`ifdef XBAR_ARB_TIMEOUT_EN
            to_q <= '0;
            for (int j = 0; j < PORTS; j++) begin
                hold[j] <= '0;
            end
`endif
        end else begin
`ifdef XBAR_ARB_TIMEOUT_EN
            to_q <= '0;
`endif
            for (int j = 0; j < PORTS; j++) begin
                case (state[j])
                    IDLE: begin
                        if (win_found[j]) begin
                            state[j]                  <= BUSY;
                            busy_q[j]                 <= 1'b1;
                            sel_q[j*SEL_W +: SEL_W]   <= win_idx[j];
                            grant_q[win_idx[j]]       <= 1'b1;
                            ptr[j]                    <= (win_idx[j] == SEL_W'(PORTS - 1))
                                                         ? '0 : win_idx[j] + 1'b1;
`ifdef XBAR_ARB_TIMEOUT_EN
                            hold[j]                   <= '0;
`endif
                        end
                    end
                    BUSY: begin
                        // Release lands in the IDLE cycle, so the next winner is seen one cycle later.
                        if (owner_eop[j] || expire[j]) begin
                            state[j]          <= IDLE;
                            busy_q[j]         <= 1'b0;
                            grant_q[owner[j]] <= 1'b0;
                        end
`ifdef XBAR_ARB_TIMEOUT_EN
                        hold[j] <= hold[j] + 1'b1;
                        if (expire[j] && !owner_eop[j]) begin
                            to_q[j] <= 1'b1;
                        end
`endif
                    end
                    default: state[j] <= IDLE;
                endcase
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.out_sel  = sel_q;
    assign bus.out_busy = busy_q;
endmodule

// File: tb/tb_xbar_arbiter.sv
// tb/tb_xbar_arbiter.sv - scoreboard bench for xbar_arbiter with directed request vectors
module tb_xbar_arbiter;
    localparam int P    = 8;
    localparam int SW   = 3;
    localparam int HOLD = 16;

    typedef struct {
        int            at;
        logic [P-1:0]  grant;
        logic [P-1:0]  busy;
        logic [P*SW-1:0] sel;
        logic [P-1:0]  tp;
    } snap_t;

    typedef struct {
        int src;
        int dst;
    } gnt_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    snap_t exp_q[$];
    gnt_t  gnt_q[$];
    snap_t mon_s;
    gnt_t  mon_g;

    logic [P-1:0]    e_grant    = '0;
    logic [P-1:0]    e_busy     = '0;
    logic [P-1:0]    e_tp       = '0;
    logic [P*SW-1:0] e_sel      = '0;
    logic [P-1:0]    prev_grant = '0;

    xbar_arbiter_if #(.PORTS(P), .SEL_W(SW)) bus ();

    xbar_arbiter #(.PORTS(P), .SEL_W(SW), .MAX_HOLD(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endtask

    // Monitor: state snapshots due this cycle, plus grant-order events on every new grant.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            mon_s = exp_q.pop_front();
            if (mon_s.at != cyc) check("sched", cyc, mon_s.at);
            check("grant", bus.grant, mon_s.grant);
            check("out_busy", bus.out_busy, mon_s.busy);
            check("out_sel", bus.out_sel, mon_s.sel);
            check("timeout_pulse", bus.timeout_pulse, mon_s.tp);
        end
        for (int i = 0; i < P; i++) begin
            if (bus.grant[i] === 1'b1 && prev_grant[i] !== 1'b1) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", i, 99);
                end else begin
                    mon_g = gnt_q.pop_front();
                    check("gnt_src", i, mon_g.src);
                    check("gnt_sel", bus.out_sel[mon_g.dst*SW +: SW], mon_g.src);
                end
            end
        end
        prev_grant = bus.grant;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic expect_for(input int from, input int n);
        snap_t s;
        for (int k = 0; k < n; k++) begin
            s.at    = from + k;
            s.grant = e_grant;
            s.busy  = e_busy;
            s.sel   = e_sel;
            s.tp    = e_tp;
            exp_q.push_back(s);
        end
    endtask

    task automatic set_sel(input int j, input int v);
        e_sel[j*SW +: SW] = SW'(v);
    endtask

    task automatic request(input int i, input int d);
        bus.req_valid[i]         = 1'b1;
        bus.req_dest[i*SW +: SW] = SW'(d);
    endtask

    task automatic push_gnt(input int s, input int d);
        gnt_t g;
        g.src = s;
        g.dst = d;
        gnt_q.push_back(g);
    endtask

    initial begin
        int t;
        int g;
        int w;
        int order [4];
        order = '{0, 2, 6, 0};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_dest  = '0;
        bus.req_eop   = '0;
        step(2);
        rst = 1'b0;

        // Reset then idle
        expect_for(cyc, 21);
        step(21);

        // Single request 3 -> 5, stray EOP from a non-owner, then release
        t = cyc;
        request(3, 5);
        push_gnt(3, 5);
        e_grant = 8'h08; e_busy = 8'h20; set_sel(5, 3);
        expect_for(t + 1, 10);
        step(3);
        bus.req_eop[2] = 1'b1;
        step(1);
        bus.req_eop[2] = 1'b0;
        to_cycle(t + 10);
        bus.req_eop[3] = 1'b1; bus.req_valid[3] = 1'b0;
        e_grant = '0; e_busy = '0;
        expect_for(t + 11, 3);
        step(1);
        bus.req_eop[3] = 1'b0;
        step(3);

        // Round-robin on output 1 among inputs 0, 2, 6
        t = cyc;
        request(0, 1); request(2, 1); request(6, 1);
        for (int k = 0; k < 4; k++) begin
            g = t + 1 + 6 * k;
            w = order[k];
            push_gnt(w, 1);
            e_grant = '0; e_grant[w] = 1'b1; e_busy = 8'h02; set_sel(1, w);
            expect_for(g, 5);
            e_grant = '0; e_busy = '0;
            expect_for(g + 5, 1);
            to_cycle(g + 4);
            bus.req_eop[w] = 1'b1;
            if (k == 3) bus.req_valid = '0;
            step(1);
            bus.req_eop[w] = 1'b0;
        end
        step(2);

        // All outputs in parallel; input 0 retargets mid-packet
        t = cyc;
        for (int i = 0; i < P; i++) begin
            request(i, 7 - i);
            push_gnt(i, 7 - i);
            set_sel(7 - i, i);
        end
        e_grant = 8'hFF; e_busy = 8'hFF;
        expect_for(t + 1, 6);
        step(2);
        bus.req_dest[0 +: SW] = 3'd3;
        to_cycle(t + 6);
        bus.req_eop = '1; bus.req_valid = '0;
        e_grant = '0; e_busy = '0;
        expect_for(t + 7, 2);
        step(1);
        bus.req_eop = '0;
        step(2);

        // Reset mid-packet on output 2, then pointer restarts from 0
        t = cyc;
        request(1, 2); request(4, 2);
        push_gnt(1, 2);
        e_grant = 8'h02; e_busy = 8'h04; set_sel(2, 1);
        expect_for(t + 1, 2);
        step(2);
        rst = 1'b1;
        e_grant = '0; e_busy = '0; e_sel = '0;
        expect_for(t + 3, 1);
        step(1);
        rst = 1'b0;
        push_gnt(1, 2);
        e_grant = 8'h02; e_busy = 8'h04; set_sel(2, 1);
        expect_for(t + 4, 2);
        step(2);
        bus.req_eop[1] = 1'b1; bus.req_valid[1] = 1'b0;
        e_grant = '0; e_busy = '0;
        expect_for(t + 6, 1);
        push_gnt(4, 2);
        e_grant = 8'h10; e_busy = 8'h04; set_sel(2, 4);
        expect_for(t + 7, 2);
        step(1);
        bus.req_eop[1] = 1'b0;
        to_cycle(t + 8);
        bus.req_eop[4] = 1'b1; bus.req_valid[4] = 1'b0;
        e_grant = '0; e_busy = '0;
        expect_for(t + 9, 2);
        step(1);
        bus.req_eop[4] = 1'b0;
        step(2);

        // Hold timeout on output 0 owned by input 5
        t = cyc;
        request(5, 0);
        push_gnt(5, 0);
        e_grant = 8'h20; e_busy = 8'h01; set_sel(0, 5);
        g = t + 1;
`ifdef XBAR_ARB_TIMEOUT_EN
        expect_for(g, HOLD);
        step(5);
        bus.req_valid[5] = 1'b0;
        e_grant = '0; e_busy = '0; e_tp = 8'h01;
        expect_for(g + HOLD, 1);
        e_tp = '0;
        expect_for(g + HOLD + 1, 2);
        to_cycle(g + HOLD + 2);

        // EOP on the expiry cycle is an ordinary release without a pulse
        t = cyc;
        request(5, 0);
        push_gnt(5, 0);
        e_grant = 8'h20; e_busy = 8'h01; set_sel(0, 5);
        g = t + 1;
        expect_for(g, HOLD);
        to_cycle(g + HOLD - 1);
        bus.req_eop[5] = 1'b1; bus.req_valid[5] = 1'b0;
        e_grant = '0; e_busy = '0;
        expect_for(g + HOLD, 2);
        step(1);
        bus.req_eop[5] = 1'b0;
        step(3);
`else
        expect_for(g, 100);
        to_cycle(g + 99);
        bus.req_eop[5] = 1'b1; bus.req_valid[5] = 1'b0;
        e_grant = '0; e_busy = '0;
        expect_for(g + 100, 2);
        step(1);
        bus.req_eop[5] = 1'b0;
        step(3);
`endif

        step(3);
        check("exp_q_drained", exp_q.size(), 0);
        check("gnt_q_drained", gnt_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
        $fatal(1);
    end
endmodule
